// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - SCAN elevator request scheduler and tick-timed motion sequencer
module elevator_ctrl #(
    parameter int N_FLOOR    = 4,
    parameter int FW         = $clog2(N_FLOOR),
    parameter int MOVE_TICKS = 2,
    parameter int DOOR_TICKS = 3
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               tick,
    input  logic [N_FLOOR-1:0] req,
    output logic [FW-1:0]      floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic [N_FLOOR-1:0] pending
);

    localparam int MAX_T = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int CW    = $clog2(MAX_T + 1);
    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FW-1:0]      floor_q, floor_d;
    logic               dir_up_q, dir_up_d;
    logic [N_FLOOR-1:0] pending_q, pending_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               moving_q, door_q;

    logic               above, below, here;
    logic [FW-1:0]      floor_step;
    logic [CW-1:0]      cnt_inc;
    logic [N_FLOOR-1:0] clr;

    function automatic logic [N_FLOOR-1:0] onehot(input logic [FW-1:0] f);
        logic [N_FLOOR-1:0] v;
        v    = '0;
        v[f] = 1'b1;
        return v;
    endfunction

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < N_FLOOR; i++) begin
            if (pending_q[i]) begin
                if (i > int'(floor_q)) above = 1'b1;
                if (i < int'(floor_q)) below = 1'b1;
            end
        end
        here       = pending_q[floor_q];
        floor_step = dir_up_q ? floor_q + FW'(1) : floor_q - FW'(1);
        cnt_inc    = cnt_q + CW'(1);
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        clr      = '0;
        case (state_q)
            S_IDLE: begin
                // Ticks are ignored here; the counter is held clear for the next state.
                cnt_d = '0;
                if (here) begin
                    state_d = S_DOOR;
                    clr     = onehot(floor_q);
                end else if (dir_up_q && above) begin
                    state_d = S_MOVE;
                end else if (!dir_up_q && below) begin
                    state_d = S_MOVE;
                end else if (above) begin
                    dir_up_d = 1'b1;
                    state_d  = S_MOVE;
                end else if (below) begin
                    dir_up_d = 1'b0;
                    state_d  = S_MOVE;
                end
            end
            S_MOVE: begin
                if (tick) begin
                    if (cnt_inc == MOVE_LAST) begin
                        floor_d = floor_step;
                        cnt_d   = '0;
                        // A call at the arriving floor, latched or live, stops the car there.
                        if (pending_q[floor_step] || req[floor_step]) begin
                            state_d = S_DOOR;
                            clr     = onehot(floor_step);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_DOOR: begin
                clr = onehot(floor_q);
                if (tick) begin
                    if (cnt_inc == DOOR_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        pending_d = (pending_q | req) & ~clr;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= S_IDLE;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            pending_q <= '0;
            cnt_q     <= '0;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            moving_q  <= (state_d == S_MOVE);
            door_q    <= (state_d == S_DOOR);
        end
    end

    assign floor     = floor_q;
    assign dir_up    = dir_up_q;
    assign moving    = moving_q;
    assign door_open = door_q;
    assign pending   = pending_q;

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Request scheduler and motion sequencer for the elevator experiment. It latches floor-call buttons and picks a travel direction with a SCAN (keep-direction) policy. It times floor-to-floor travel and door dwell by counting single-cycle tick pulses, which come from the design's clock-divider outputs after they are converted to enables. Its outputs drive the floor display, direction LEDs and door indicator.

## Interface
Parameters:
- N_FLOOR, 4, number of floors; legal 2..16
- FW, $clog2(N_FLOOR), floor index width
- MOVE_TICKS, 2, ticks to travel one floor; ≥1
- DOOR_TICKS, 3, ticks the door stays open; ≥1

Ports:
- clk_in  in  1  system clock; everything is synchronous to its rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  timing enable; one-cycle pulse, already synchronous to clk_in
- req  in  N_FLOOR  call buttons, one bit per floor; level or pulse, sampled every cycle
- floor  out  FW  current floor index
- dir_up  out  1  1 = current/last direction is up
- moving  out  1  high in MOVE
- door_open  out  1  high in DOOR
- pending  out  N_FLOOR  latched outstanding calls

## Operation
- States are IDLE, MOVE and DOOR. All outputs are registered.
- Call latching: each cycle, pending <= (pending | req) & ~clr. clr is the one-hot of floor while the state is DOOR, or the one-hot of the next floor when entering DOOR. When a set and a clear hit the same bit, the clear wins.
- above = |pending bits with index > floor; below = |pending bits with index < floor; here = pending[floor].
- IDLE, evaluated every cycle, priority order:
  - here → DOOR, clear that bit.
  - else dir_up & above → MOVE up.
  - else !dir_up & below → MOVE down.
  - else above → dir_up=1, MOVE.
  - else below → dir_up=0, MOVE.
  - else stay in IDLE.
- MOVE: tick_cnt counts ticks seen while in MOVE. On the tick that makes the count reach MOVE_TICKS, floor steps ±1 per dir_up and tick_cnt clears.
  - If the new floor's pending bit is set, or req at the new floor is asserted in that cycle, go to DOOR in the same edge.
  - Otherwise stay in MOVE.
  - MOVE is only entered with a request ahead, so floor never leaves 0..N_FLOOR-1.
- DOOR: pending[floor] is held clear, so presses at the open floor are absorbed and do not extend dwell. After DOOR_TICKS ticks, go to IDLE; the next cycle IDLE re-evaluates using the dir_up preference.
- tick_cnt clears on every state entry. A tick in an IDLE cycle is ignored.

## Timing
- Reset values: state=IDLE, floor=0, dir_up=1, moving=0, door_open=0, pending=0, tick_cnt=0. rst overrides all other inputs in the same edge.
- rst asserted mid-MOVE or mid-DOOR returns to floor 0 / IDLE on the next edge; there is no partial-travel state.
- req → pending: 1-cycle latency.
- Request at an idle car on another floor: pending at edge 1, moving at edge 2.
- Request at the idle car's own floor: door_open asserts 2 edges after req. The bit appears in pending for 1 cycle, then clears.
- Travel: after MOVE entry, floor changes on the edge that samples the MOVE_TICKS-th tick. A tick coincident with the entry edge is not counted.
- Door: door_open deasserts on the edge sampling the DOOR_TICKS-th tick in DOOR. The next move starts ≥1 cycle later, through IDLE.
- With requests present at top and bottom, the car reverses only after all calls in the current direction are served.

## Test plan
- Reset: after rst, floor=0, dir_up=1, moving=0, door_open=0, pending=0. Then hold rst high with req=4'b1111 → pending stays 0.
- Single call up, MOVE_TICKS=2, DOOR_TICKS=3, tick every 4 cycles:
  - req[2] pulse at floor 0 → moving=1, floor 0→1→2 after 2 ticks each.
  - door_open=1 at floor 2 for 3 ticks, pending[2] clears, then IDLE.
- SCAN order: car at floor 1 moving up, pending {0,3} → serves 3 first (dir_up=1), then reverses (dir_up=0) to 0. Floor 2 is not stopped at.
- Call on the route: while travelling 0→3, pulse req[2] before the car reaches floor 2 → door opens at 2, then the car continues to 3.
- Own-floor call: idle at floor 0, req[0]=1 for 10 cycles → a single DOOR visit of exactly DOOR_TICKS ticks. pending[0]=0 at exit.
- Reset mid-move: rst during MOVE between floors 1 and 2 → next edge floor=0, IDLE, pending=0. A subsequent req[3] is served normally.
